// File: rtl/pooling_pkg.sv
// Shared definitions for the pooling-layer sequencer: FSM state encoding,
// the log2 helper used to size index/address ports, and the float32 -inf word.
package pooling_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [31:0] FLOAT32_NEG_INF = 32'hFF80_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        EMIT  = 3'd5,
        DONE  = 3'd6
    } pool_ctrl_state_t;

    // Bits needed to hold values 0..value-1 (never less than one bit).
    function automatic int logb2(input int value);
        int res;
        res = 1;
        for (int i = 1; i < 31; i++) begin
            if (value > (32'sd1 <<< i)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pooling_index_gen.sv
// Nested c (outer) / r (middle) / f (inner) counters for the pooling sequencer.
// next_addr is the buffer address of the counter values that will be current
// after this cycle's clear/advance, so the caller can register it on the same
// edge the counters move.
module pooling_index_gen import pooling_pkg::*; #(
    parameter int INPUT_SIZE    = 6,
    parameter int KERNEL_SIZE   = 2,
    parameter int TOTAL_FEATURE = 4
) (
    input  logic                                                        clk,
    input  logic                                                        rst_n,
    input  logic                                                        clear,
    input  logic                                                        advance,
    output logic [logb2(TOTAL_FEATURE)-1:0]                             f,
    output logic [logb2(INPUT_SIZE)-1:0]                                r,
    output logic [logb2(INPUT_SIZE/KERNEL_SIZE)-1:0]                    c,
    output logic                                                        last,
    output logic                                                        emit_row,
    output logic [logb2(TOTAL_FEATURE*INPUT_SIZE*(INPUT_SIZE/KERNEL_SIZE))-1:0] next_addr
);

    localparam int POOL_CELLS = INPUT_SIZE / KERNEL_SIZE;
    localparam int F_W        = logb2(TOTAL_FEATURE);
    localparam int R_W        = logb2(INPUT_SIZE);
    localparam int C_W        = logb2(POOL_CELLS);
    localparam int ADDR_W     = logb2(TOTAL_FEATURE * INPUT_SIZE * POOL_CELLS);

    localparam logic [F_W-1:0] F_MAX = F_W'(TOTAL_FEATURE - 1);
    localparam logic [R_W-1:0] R_MAX = R_W'(INPUT_SIZE - 1);
    localparam logic [C_W-1:0] C_MAX = C_W'(POOL_CELLS - 1);

    logic [F_W-1:0] f_next_s;
    logic [R_W-1:0] r_next_s;
    logic [C_W-1:0] c_next_s;

    // Next counter values: f wraps into r, r wraps into c, all wrap after the last cell.
    always_comb begin
        f_next_s = f;
        r_next_s = r;
        c_next_s = c;
        if (clear) begin
            f_next_s = '0;
            r_next_s = '0;
            c_next_s = '0;
        end else if (advance) begin
            if (f == F_MAX) begin
                f_next_s = '0;
                if (r == R_MAX) begin
                    r_next_s = '0;
                    if (c == C_MAX) begin
                        c_next_s = '0;
                    end else begin
                        c_next_s = c + 1'b1;
                    end
                end else begin
                    r_next_s = r + 1'b1;
                end
            end else begin
                f_next_s = f + 1'b1;
            end
        end else begin
            f_next_s = f;
        end
    end

    assign last      = (f == F_MAX) && (r == R_MAX) && (c == C_MAX);
    assign emit_row  = ((r % R_W'(KERNEL_SIZE)) == R_W'(KERNEL_SIZE - 1));
    assign next_addr = ADDR_W'((32'(f_next_s) * 32'(INPUT_SIZE) + 32'(r_next_s))
                               * 32'(POOL_CELLS) + 32'(c_next_s));

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f <= '0;
            r <= '0;
            c <= '0;
        end else begin
            f <= f_next_s;
            r <= r_next_s;
            c <= c_next_s;
        end
    end

endmodule

// File: rtl/pooling_ctrl.sv
// Sequencer for one pooling_kernel: reads window rows from the pooling input
// buffer, issues them to the kernel and forwards each finished max-pool value
// downstream with valid/ready.
// Optional macro POOL_CTRL_PERF_EN adds perf_cycles / perf_stall counters.
module pooling_ctrl import pooling_pkg::*; #(
    parameter int INPUT_SIZE    = 6,
    parameter int KERNEL_SIZE   = 2,
    parameter int TOTAL_FEATURE = 4
) (
    input  logic                                                        clk,
    input  logic                                                        rst_n,
    input  logic                                                        start,
    output logic                                                        busy,
    output logic                                                        done,
    output logic                                                        err,
    output logic                                                        buf_rd_en,
    output logic [logb2(TOTAL_FEATURE*INPUT_SIZE*(INPUT_SIZE/KERNEL_SIZE))-1:0] buf_rd_addr,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]                           buf_rd_data,
    output logic                                                        krn_input_valid,
    output logic [logb2(TOTAL_FEATURE)-1:0]                             krn_feature_idx,
    output logic [logb2(INPUT_SIZE)-1:0]                                krn_feature_row,
    output logic [KERNEL_SIZE*DATA_WIDTH-1:0]                           krn_data_in,
    input  logic                                                        krn_output_valid,
    input  logic [DATA_WIDTH-1:0]                                       krn_data_out,
    output logic                                                        out_valid,
    input  logic                                                        out_ready,
    output logic [DATA_WIDTH-1:0]                                       out_data,
    output logic [logb2(TOTAL_FEATURE)-1:0]                             out_feature,
    output logic [logb2(INPUT_SIZE/KERNEL_SIZE)-1:0]                    out_row,
    output logic [logb2(INPUT_SIZE/KERNEL_SIZE)-1:0]                    out_col
`ifdef POOL_CTRL_PERF_EN
    ,
    output logic [31:0]                                                 perf_cycles,
    output logic [31:0]                                                 perf_stall
`endif
);

    localparam int POOL_CELLS = INPUT_SIZE / KERNEL_SIZE;
    localparam int F_W        = logb2(TOTAL_FEATURE);
    localparam int R_W        = logb2(INPUT_SIZE);
    localparam int C_W        = logb2(POOL_CELLS);
    localparam int ADDR_W     = logb2(TOTAL_FEATURE * INPUT_SIZE * POOL_CELLS);

    pool_ctrl_state_t  state_r;
    logic [F_W-1:0]    f_s;
    logic [R_W-1:0]    r_s;
    logic [C_W-1:0]    c_s;
    logic              last_s;
    logic              emit_row_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic              idx_clear_s;
    logic              idx_advance_s;

    // Counters restart on an accepted start and step after each finished row
    // that is not emitted, or after each accepted output.
    assign idx_clear_s   = (state_r == IDLE) && start;
    assign idx_advance_s = ((state_r == WAIT) && krn_output_valid && !emit_row_s)
                        || ((state_r == EMIT) && out_ready);

    pooling_index_gen #(
        .INPUT_SIZE    (INPUT_SIZE),
        .KERNEL_SIZE   (KERNEL_SIZE),
        .TOTAL_FEATURE (TOTAL_FEATURE)
    ) u_index_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (idx_clear_s),
        .advance   (idx_advance_s),
        .f         (f_s),
        .r         (r_s),
        .c         (c_s),
        .last      (last_s),
        .emit_row  (emit_row_s),
        .next_addr (next_addr_s)
    );

    // Main FSM; every output is a flop set on the edge that enters its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            buf_rd_en       <= 1'b0;
            buf_rd_addr     <= '0;
            krn_input_valid <= 1'b0;
            krn_feature_idx <= '0;
            krn_feature_row <= '0;
            krn_data_in     <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_feature     <= '0;
            out_row         <= '0;
            out_col         <= '0;
        end else begin
            buf_rd_en       <= 1'b0;
            krn_input_valid <= 1'b0;
            done            <= 1'b0;
            if (krn_output_valid && (state_r != WAIT)) begin
                err <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        err         <= 1'b0;
                        buf_rd_en   <= 1'b1;
                        buf_rd_addr <= next_addr_s;
                        state_r     <= FETCH;
                    end
                end
                FETCH: begin
                    state_r <= LOAD;
                end
                LOAD: begin
                    krn_data_in     <= buf_rd_data;
                    krn_input_valid <= 1'b1;
                    krn_feature_idx <= f_s;
                    krn_feature_row <= r_s;
                    state_r         <= ISSUE;
                end
                ISSUE: begin
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (krn_output_valid) begin
                        if (emit_row_s) begin
                            out_valid   <= 1'b1;
                            out_data    <= krn_data_out;
                            out_feature <= f_s;
                            out_row     <= C_W'(r_s / R_W'(KERNEL_SIZE));
                            out_col     <= c_s;
                            state_r     <= EMIT;
                        end else begin
                            buf_rd_en   <= 1'b1;
                            buf_rd_addr <= next_addr_s;
                            state_r     <= FETCH;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_s) begin
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            buf_rd_en   <= 1'b1;
                            buf_rd_addr <= next_addr_s;
                            state_r     <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef POOL_CTRL_PERF_EN
    // Busy-cycle and output-stall counters; cleared by an accepted start, held after done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= 32'd0;
            perf_stall  <= 32'd0;
        end else if (idx_clear_s) begin
            perf_cycles <= 32'd0;
            perf_stall  <= 32'd0;
        end else begin
            if (busy) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if ((state_r == EMIT) && !out_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
